mem_bus_arbiter: RTL

Two-master burst arbiter sharing the single system-memory burst port between the L1 instruction-refill path (read-only) and the L1 data path (refill read or writeback write).
- Sits between the L1 cache controller and the system memory, in the sys_clk domain.
- Grants the port round-robin and locks the owner for a whole burst.
- Sequences address phase, data beats and completion.

---
 rtl/mem_bus_arbiter_pkg.sv | 25 ++
 rtl/mem_bus_arbiter_rr_pick2.sv | 21 ++
 rtl/mem_bus_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the two-master memory burst arbiter.
// Owner encoding, FSM states and the burst-length helper live here.
package mem_bus_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        RDATA = 3'd2,
        WDATA = 3'd3,
        DONE  = 3'd4
    } arb_state_t;

    localparam int DEF_READ_BURST_LEN  = 8;
    localparam int DEF_WRITE_BURST_LEN = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the master
// that did not own the previous burst wins.
module rr_pick2
    import mem_bus_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     last_owner_i,
    output owner_t     winner_o
);

    always_comb begin
        winner_o = OWN_I;
        case (req_i)
            2'b01:   winner_o = OWN_I;
            2'b10:   winner_o = OWN_D;
            2'b11:   winner_o = (last_owner_i == OWN_I) ? OWN_D : OWN_I;
            default: winner_o = OWN_I;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Burst arbiter sharing one system-memory port between the instruction-refill
// and data paths; the owner is locked from address phase through completion.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int READ_BURST_LEN  = DEF_READ_BURST_LEN,
    parameter int WRITE_BURST_LEN = DEF_WRITE_BURST_LEN,
    localparam int CNT_W          = $clog2(max2(READ_BURST_LEN, WRITE_BURST_LEN))
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_wnext,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    output logic                  mem_wvalid,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_wready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output arb_state_t            dbg_state_o,
    output logic [CNT_W-1:0]      dbg_beat_cnt_o
);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_BURST_LEN - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_BURST_LEN - 1);

    // Handshakes: mem_req holds until mem_ack; a read beat moves on
    // mem_rvalid alone; a write beat moves when mem_wvalid && mem_wready.
    arb_state_t            state_q;
    owner_t                owner_q;
    owner_t                last_owner_q;
    owner_t                winner;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [CNT_W-1:0]      beat_cnt_q;
    logic                  mem_req_q;
    logic                  i_done_q;
    logic                  d_done_q;

    rr_pick2 u_pick (
        .req_i        ({d_req, i_req}),
        .last_owner_i (last_owner_q),
        .winner_o     (winner)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            addr_q       <= '0;
            we_q         <= 1'b0;
            beat_cnt_q   <= '0;
            mem_req_q    <= 1'b0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner_q   <= winner;
                        addr_q    <= (winner == OWN_I) ? i_addr : d_addr;
                        we_q      <= (winner == OWN_D) && d_we;
                        mem_req_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (mem_ack) begin
                        mem_req_q  <= 1'b0;
                        beat_cnt_q <= '0;
                        state_q    <= we_q ? WDATA : RDATA;
                    end
                end
                RDATA: begin
                    if (mem_rvalid) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (beat_cnt_q == RD_LAST) begin
                            state_q  <= DONE;
                            i_done_q <= (owner_q == OWN_I);
                            d_done_q <= (owner_q == OWN_D);
                        end
                    end
                end
                WDATA: begin
                    if (mem_wready) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (beat_cnt_q == WR_LAST) begin
                            state_q  <= DONE;
                            i_done_q <= (owner_q == OWN_I);
                            d_done_q <= (owner_q == OWN_D);
                        end
                    end
                end
                DONE: begin
                    last_owner_q <= owner_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data beats are routed combinationally so no latency is added per beat.
    logic rd_phase;
    logic wr_phase;
    assign rd_phase = (state_q == RDATA);
    assign wr_phase = (state_q == WDATA);

    assign i_gnt    = (state_q != IDLE) && (owner_q == OWN_I);
    assign d_gnt    = (state_q != IDLE) && (owner_q == OWN_D);
    assign i_rvalid = rd_phase && (owner_q == OWN_I) && mem_rvalid;
    assign d_rvalid = rd_phase && (owner_q == OWN_D) && mem_rvalid;
    assign i_rdata  = (rd_phase && (owner_q == OWN_I)) ? mem_rdata : '0;
    assign d_rdata  = (rd_phase && (owner_q == OWN_D)) ? mem_rdata : '0;
    assign i_done   = i_done_q;
    assign d_done   = d_done_q;

    assign mem_req    = mem_req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wvalid = wr_phase;
    assign mem_wdata  = wr_phase ? d_wdata : '0;
    assign d_wnext    = wr_phase && mem_wready;

    assign dbg_state_o    = state_q;
    assign dbg_beat_cnt_o = beat_cnt_q;

endmodule
